// File: rtl/bsk_com_filter.sv
// Command-line input conditioning: 2-FF synchroniser, prescaled per-channel debounce,
// change pulse and sticky change mask. Optional glitch counter under BSK_COM_GLITCH_CNT_EN.
module bsk_com_filter #(
  parameter int unsigned       WIDTH      = 16,
  parameter int unsigned       PRESCALE   = 50,
  parameter int unsigned       FILTER_LEN = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             iRes,
  input  logic [WIDTH-1:0] iComRaw,
  input  logic             iClr,
  output logic [WIDTH-1:0] oCom,
  output logic             oChange,
  output logic [WIDTH-1:0] oChangeMask,
  output logic             oTick
`ifdef BSK_COM_GLITCH_CNT_EN
  ,
  output logic [7:0]       oGlitchCnt
`endif
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } chState_t;

  logic [WIDTH-1:0] sync1, sync2;
  logic [PW-1:0]    pcnt;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cntNext [WIDTH];
  chState_t         chState [WIDTH];
  logic [WIDTH-1:0] comNext;
  logic [WIDTH-1:0] toggle;
`ifdef BSK_COM_GLITCH_CNT_EN
  logic [WIDTH-1:0] glitch;
  logic [7:0]       glitchCntNext;
  int unsigned      glitchNum;
  int unsigned      glitchSum;
`endif

  always_ff @(posedge clk or posedge iRes) begin
    if (iRes) begin
      pcnt <= '0;
    end else if (pcnt == PW'(PRESCALE - 1)) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  assign oTick = (pcnt == PW'(PRESCALE - 1));

  // Channel state is implied by its counter; STABLE already holds cnt=0.
  always_comb begin
    cntNext = cnt;
    comNext = oCom;
    toggle  = '0;
`ifdef BSK_COM_GLITCH_CNT_EN
    glitch  = '0;
`endif
    for (int unsigned i = 0; i < WIDTH; i++) begin
      chState[i] = (cnt[i] != '0) ? PENDING : STABLE;
      if (oTick) begin
        if (sync2[i] != oCom[i]) begin
          if (cnt[i] == CW'(FILTER_LEN - 1)) begin
            cntNext[i] = '0;
            comNext[i] = sync2[i];
            toggle[i]  = 1'b1;
          end else begin
            cntNext[i] = cnt[i] + 1'b1;
          end
        end else if (chState[i] == PENDING) begin
          cntNext[i] = '0;
`ifdef BSK_COM_GLITCH_CNT_EN
          glitch[i]  = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge iRes) begin
    if (iRes) begin
      sync1       <= RESET_VAL;
      sync2       <= RESET_VAL;
      oCom        <= RESET_VAL;
      cnt         <= '{default: '0};
      oChange     <= 1'b0;
      oChangeMask <= '0;
    end else begin
      sync1       <= iComRaw;
      sync2       <= sync1;
      oCom        <= comNext;
      cnt         <= cntNext;
      oChange     <= |toggle;
      oChangeMask <= (iClr ? '0 : oChangeMask) | toggle;
    end
  end

`ifdef BSK_COM_GLITCH_CNT_EN
  // Saturating add of this tick's rejections; a clear overrides any increment.
  always_comb begin
    glitchNum = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      glitchNum += {31'd0, glitch[i]};
    end
    glitchSum = {24'd0, oGlitchCnt} + glitchNum;
    if (iClr) begin
      glitchCntNext = '0;
    end else if (glitchSum > 32'd255) begin
      glitchCntNext = '1;
    end else begin
      glitchCntNext = glitchSum[7:0];
    end
  end

  always_ff @(posedge clk or posedge iRes) begin
    if (iRes) begin
      oGlitchCnt <= '0;
    end else begin
      oGlitchCnt <= glitchCntNext;
    end
  end
`endif

endmodule

// File: tb/tb_bsk_com_filter.sv
// Self-checking bench for bsk_com_filter against a tick-sample-history reference model.
module tb_bsk_com_filter;

  localparam int P = 4;
  localparam int F = 3;

  logic        clk = 1'b0;
  logic        iRes = 1'b1;
  logic [15:0] iComRaw = 16'hFFFF;
  logic        iClr = 1'b0;
  logic [15:0] oCom;
  logic        oChange;
  logic [15:0] oChangeMask;
  logic        oTick;
`ifdef BSK_COM_GLITCH_CNT_EN
  logic [7:0]  oGlitchCnt;
`endif

  int errors = 0;
  int checks = 0;

  bsk_com_filter #(
    .WIDTH(16),
    .PRESCALE(P),
    .FILTER_LEN(F),
    .RESET_VAL(16'h0000)
  ) dut (
    .clk(clk),
    .iRes(iRes),
    .iComRaw(iComRaw),
    .iClr(iClr),
    .oCom(oCom),
    .oChange(oChange),
    .oChangeMask(oChangeMask),
    .oTick(oTick)
`ifdef BSK_COM_GLITCH_CNT_EN
    ,
    .oGlitchCnt(oGlitchCnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference: a level is accepted once the last F tick samples all disagree with it.
  logic [15:0] mRaw1 = 16'h0, mRaw2 = 16'h0;
  logic [15:0] samp[$];
  logic [15:0] mCom = 16'h0, mMask = 16'h0;
  logic        mChange = 1'b0;
  int          nClk = 0;
  int          mGlitch = 0;

  always @(posedge clk or posedge iRes) begin
    logic [15:0] s, flips;
    int g;
    bit allDiff;
    if (iRes) begin
      mRaw1 = 16'h0; mRaw2 = 16'h0;
      samp.delete();
      mCom = 16'h0; mMask = 16'h0; mChange = 1'b0;
      nClk = 0; mGlitch = 0;
    end else begin
      s = mRaw2; mRaw2 = mRaw1; mRaw1 = iComRaw;
      flips = 16'h0; g = 0;
      if (nClk % P == P - 1) begin
        for (int b = 0; b < 16; b++)
          if (samp.size() > 0 && samp[samp.size()-1][b] != mCom[b] && s[b] == mCom[b]) g++;
        samp.push_back(s);
        if (samp.size() > F) void'(samp.pop_front());
        if (samp.size() == F)
          for (int b = 0; b < 16; b++) begin
            allDiff = 1'b1;
            for (int k = 0; k < F; k++) if (samp[k][b] == mCom[b]) allDiff = 1'b0;
            flips[b] = allDiff;
          end
        mCom = mCom ^ flips;
      end
      mChange = |flips;
      mMask = (iClr ? 16'h0 : mMask) | flips;
      mGlitch = iClr ? 0 : ((mGlitch + g > 255) ? 255 : mGlitch + g);
      nClk++;
    end
  end

  task automatic test_reset();
    iRes = 1'b1; iComRaw = 16'hFFFF; iClr = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (oCom !== 16'h0000) begin errors++; $display("FAIL reset_oCom: got %h expected 0000", oCom); end
    checks++; if (oChange !== 1'b0) begin errors++; $display("FAIL reset_oChange: got %b expected 0", oChange); end
    checks++; if (oChangeMask !== 16'h0000) begin errors++; $display("FAIL reset_mask: got %h expected 0000", oChangeMask); end
    checks++; if (oTick !== 1'b0) begin errors++; $display("FAIL reset_oTick: got %b expected 0", oTick); end
`ifdef BSK_COM_GLITCH_CNT_EN
    checks++; if (oGlitchCnt !== 8'h00) begin errors++; $display("FAIL reset_glitch: got %h expected 00", oGlitchCnt); end
`endif
  endtask

  task automatic test_step();
    int lat = 0, pulses = 0;
    iRes = 1'b0; iComRaw = 16'h1331;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (oChange === 1'b1) pulses++;
      if (lat == 0 && oCom === 16'h1331) lat = n;
    end
    checks++; if (lat < 11 || lat > 14) begin errors++; $display("FAIL step_latency: got %0d expected 11..14", lat); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL step_pulses: got %0d expected 1", pulses); end
    checks++; if (oChangeMask !== 16'h1331) begin errors++; $display("FAIL step_mask: got %h expected 1331", oChangeMask); end
    checks++; if (oCom !== mCom) begin errors++; $display("FAIL step_model: got %h expected %h", oCom, mCom); end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    bit bad = 1'b0;
    iComRaw = 16'h0000;
    repeat (20) @(negedge clk);
    iClr = 1'b1; @(negedge clk); iClr = 1'b0;
    iComRaw[0] = 1'b1;
    repeat (6) @(negedge clk);
    iComRaw[0] = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (oChange === 1'b1) pulses++;
      if (oCom !== 16'h0000) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL glitch_oCom: got %h expected 0000 throughout", oCom); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL glitch_change: got %0d pulses expected 0", pulses); end
    checks++; if (oChangeMask !== 16'h0000) begin errors++; $display("FAIL glitch_mask: got %h expected 0000", oChangeMask); end
`ifdef BSK_COM_GLITCH_CNT_EN
    checks++; if (oGlitchCnt !== 8'd1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", oGlitchCnt); end
`endif
  endtask

  task automatic align_tick(input string name);
    int n = 0;
    while (nClk % P != 0 && n < 10) begin @(negedge clk); n++; end
    checks++; if (nClk % P != 0) begin errors++; $display("FAIL %s_align: got phase %0d expected 0", name, nClk % P); end
  endtask

  task automatic test_mask();
    align_tick("mask");
    iComRaw = 16'h0010;
    repeat (11) @(negedge clk);
    iClr = 1'b1;
    @(negedge clk);
    iClr = 1'b0;
    checks++; if (oCom !== 16'h0010) begin errors++; $display("FAIL mask_toggle: got %h expected 0010", oCom); end
    checks++; if (oChangeMask !== 16'h0010) begin errors++; $display("FAIL mask_setwins: got %h expected 0010", oChangeMask); end
    checks++; if (oChange !== 1'b1) begin errors++; $display("FAIL mask_change: got %b expected 1", oChange); end
    iClr = 1'b1; @(negedge clk); iClr = 1'b0;
    checks++; if (oChangeMask !== 16'h0000) begin errors++; $display("FAIL mask_clear: got %h expected 0000", oChangeMask); end
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    align_tick("rmid");
    iComRaw = 16'h8000;
    repeat (8) @(negedge clk);
    checks++; if (oCom !== 16'h0010) begin errors++; $display("FAIL rmid_pending: got %h expected 0010", oCom); end
    iRes = 1'b1;
    #1;
    checks++; if (oCom !== 16'h0000) begin errors++; $display("FAIL rmid_async: got %h expected 0000", oCom); end
    repeat (3) @(negedge clk);
    iRes = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (lat == 0 && oCom === 16'h8000) lat = n;
    end
    checks++; if (lat < 11 || lat > 16) begin errors++; $display("FAIL rmid_latency: got %0d expected 11..16", lat); end
  endtask

  task automatic test_prescaler();
    logic s [24];
    int first = -1;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      s[n] = oTick;
      if (first < 0 && oTick === 1'b1) first = n;
    end
    checks++; if (first < 0 || first > 3) begin errors++; $display("FAIL tick_found: got %0d expected 0..3", first); end
    if (first >= 0)
      for (int n = first; n < 24; n++) begin
        checks++;
        if (s[n] !== ((n - first) % P == 0)) begin
          errors++; $display("FAIL tick_period: cycle %0d got %b expected %b", n - first, s[n], (n - first) % P == 0);
        end
      end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      checks++; if (oCom !== mCom) begin errors++; $display("FAIL rnd_oCom: cycle %0d got %h expected %h", n, oCom, mCom); end
      checks++; if (oChange !== mChange) begin errors++; $display("FAIL rnd_change: cycle %0d got %b expected %b", n, oChange, mChange); end
      checks++; if (oChangeMask !== mMask) begin errors++; $display("FAIL rnd_mask: cycle %0d got %h expected %h", n, oChangeMask, mMask); end
      checks++; if (oTick !== (nClk % P == P - 1)) begin errors++; $display("FAIL rnd_tick: cycle %0d got %b", n, oTick); end
`ifdef BSK_COM_GLITCH_CNT_EN
      checks++; if (oGlitchCnt !== mGlitch[7:0]) begin errors++; $display("FAIL rnd_glitch: cycle %0d got %0d expected %0d", n, oGlitchCnt, mGlitch); end
`endif
      if ($urandom_range(0, 5) == 0) iComRaw = iComRaw ^ 16'($urandom);
      iClr = ($urandom_range(0, 15) == 0);
    end
    iClr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_mask();
    test_reset_mid();
    test_prescaler();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
